// File: rtl/svutest_req_arbiter.sv
// svutest_req_arbiter: round-robin arbiter sharing one downstream req/payload/rsp target among N_REQ requesters
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   up_req/up_payload per-requester request and payload, held until up_rsp
//   up_rsp           per-requester completion, combinational from dn_rsp
//   dn_req/dn_payload downstream request and registered payload
//   dn_rsp           downstream acceptance
//   grant_valid      high while a transfer is outstanding
//   grant_idx        current or last granted requester
//   txn_count        completed transfers, wrapping
//   timeout_err      sticky flag for a transfer stuck TIMEOUT_CYCLES cycles
module svutest_req_arbiter #(
    parameter type T_payload = logic,
    parameter int N_REQ = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] up_req,
    input  T_payload         up_payload [N_REQ],
    output logic [N_REQ-1:0] up_rsp,
    output logic             dn_req,
    output T_payload         dn_payload,
    input  logic             dn_rsp,
    output logic             grant_valid,
    output logic [IW-1:0]    grant_idx,
    output logic [31:0]      txn_count,
    output logic             timeout_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [IW-1:0] last_grant, winner, j;
    logic any_req, done, start;
    logic [31:0] wait_cnt;
    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        winner = '0;
        any_req = 1'b0;
        j = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = IW'((int'(last_grant) + i) % N_REQ);
            if (up_req[j]) begin
                winner = j;
                any_req = 1'b1;
            end
        end
    end
    always_comb begin
        state_nx = state;
        dn_req = state == BUSY;
        grant_valid = state == BUSY;
        done = (state == BUSY) && dn_rsp;
        start = (state == IDLE) && any_req;
        up_rsp = done ? N_REQ'(1) << grant_idx : '0;
        if (start) state_nx = BUSY;
        if (done) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dn_payload <= '0;
            grant_idx <= '0;
            last_grant <= IW'(N_REQ - 1);
            txn_count <= '0;
            timeout_err <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (start) begin
                dn_payload <= up_payload[winner];
                grant_idx <= winner;
                wait_cnt <= '0;
            end
            if (done) begin
                last_grant <= grant_idx;
                txn_count <= txn_count + 32'd1;
            end
            // The stuck transfer is only flagged, never aborted.
            if (state == BUSY && !dn_rsp) begin
                wait_cnt <= wait_cnt + 32'd1;
                if (TIMEOUT_CYCLES != 0 && wait_cnt + 32'd1 == 32'(TIMEOUT_CYCLES)) timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_svutest_req_arbiter.sv
// tb_svutest_req_arbiter: directed self-checking bench for svutest_req_arbiter
module tb_svutest_req_arbiter;
    logic clk, rst, dn_req, dn_rsp, grant_valid, timeout_err;
    logic [3:0] up_req, up_rsp;
    logic [7:0] up_payload [4];
    logic [7:0] dn_payload;
    logic [1:0] grant_idx;
    logic [31:0] txn_count;
    int passed = 0, total = 0, failed = 0;

    svutest_req_arbiter #(.T_payload(logic [7:0]), .N_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .up_req(up_req), .up_payload(up_payload), .up_rsp(up_rsp),
        .dn_req(dn_req), .dn_payload(dn_payload), .dn_rsp(dn_rsp), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .txn_count(txn_count), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        up_req = '0;
        dn_rsp = 1'b0;
        foreach (up_payload[i]) up_payload[i] = '0;
        tick;
        tick;
        chk("rst_dn_req", dn_req, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_dn_payload", dn_payload, 0);
        chk("rst_up_rsp", up_rsp, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b1;
        // single requester with dn_rsp tied high
        up_req = 4'b0100;
        up_payload[2] = 8'hA5;
        dn_rsp = 1'b1;
        #1 chk("single_idle_rsp", up_rsp, 0);
        tick;
        chk("single_dn_req", dn_req, 1);
        chk("single_gv", grant_valid, 1);
        chk("single_payload", dn_payload, 8'hA5);
        chk("single_grant", grant_idx, 2);
        chk("single_up_rsp", up_rsp, 4'b0100);
        up_req = '0;
        tick;
        chk("single_done_req", dn_req, 0);
        chk("single_done_rsp", up_rsp, 0);
        chk("single_txn", txn_count, 1);
        // round robin from a fresh reset
        rst = 1'b0;
        tick;
        chk("rr_rst_txn", txn_count, 0);
        rst = 1'b1;
        up_req = 4'b1111;
        for (int i = 0; i < 4; i++) up_payload[i] = 8'h10 + 8'(i);
        dn_rsp = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick;
            chk("rr_grant", grant_idx, n % 4);
            chk("rr_payload", dn_payload, 8'h10 + n % 4);
            chk("rr_up_rsp", up_rsp, 1 << (n % 4));
            tick;
            chk("rr_bubble", dn_req, 0);
        end
        chk("rr_txn", txn_count, 6);
        // backpressure, with requester 3 arriving mid-wait
        up_req = 4'b0010;
        up_payload[1] = 8'h5B;
        up_payload[3] = 8'h3C;
        dn_rsp = 1'b0;
        tick;
        for (int n = 1; n <= 5; n++) begin
            chk("bp_dn_req", dn_req, 1);
            chk("bp_payload", dn_payload, 8'h5B);
            chk("bp_up_rsp", up_rsp, 0);
            if (n == 3) up_req = 4'b1010;
            tick;
        end
        dn_rsp = 1'b1;
        #1;
        chk("bp_6th_up_rsp", up_rsp, 4'b0010);
        chk("bp_6th_grant", grant_idx, 1);
        up_req = 4'b1000;
        tick;
        chk("bp_idle_req", dn_req, 0);
        chk("bp_idle_rsp", up_rsp, 0);
        chk("bp_txn", txn_count, 7);
        tick;
        chk("bp_next_grant", grant_idx, 3);
        chk("bp_next_payload", dn_payload, 8'h3C);
        chk("bp_next_rsp", up_rsp, 4'b1000);
        up_req = '0;
        tick;
        chk("bp_txn2", txn_count, 8);
        chk("bp_no_timeout", timeout_err, 0);
        // watchdog
        up_req = 4'b0001;
        up_payload[0] = 8'h77;
        dn_rsp = 1'b0;
        tick;
        for (int n = 0; n < 7; n++) tick;
        chk("wd_before", timeout_err, 0);
        tick;
        tick;
        chk("wd_after", timeout_err, 1);
        chk("wd_still_busy", dn_req, 1);
        dn_rsp = 1'b1;
        #1 chk("wd_up_rsp", up_rsp, 4'b0001);
        up_req = '0;
        tick;
        chk("wd_txn", txn_count, 9);
        chk("wd_idle", dn_req, 0);
        tick;
        chk("wd_sticky", timeout_err, 1);
        // reset mid-transfer
        up_req = 4'b0100;
        up_payload[2] = 8'h99;
        dn_rsp = 1'b0;
        tick;
        chk("mr_busy", dn_req, 1);
        dn_rsp = 1'b1;
        #1 chk("mr_rsp_before", up_rsp, 4'b0100);
        rst = 1'b0;
        #1;
        chk("mr_dn_req", dn_req, 0);
        chk("mr_gv", grant_valid, 0);
        chk("mr_up_rsp", up_rsp, 0);
        chk("mr_txn", txn_count, 0);
        chk("mr_timeout", timeout_err, 0);
        up_req = '0;
        dn_rsp = 1'b0;
        tick;
        rst = 1'b1;
        up_req = 4'b1001;
        up_payload[0] = 8'h01;
        up_payload[3] = 8'h33;
        tick;
        chk("mr_prio_grant", grant_idx, 0);
        chk("mr_prio_payload", dn_payload, 8'h01);
        dn_rsp = 1'b1;
        #1;
        up_req = 4'b1000;
        tick;
        chk("mr_txn1", txn_count, 1);
        tick;
        chk("mr_second_grant", grant_idx, 3);
        chk("mr_second_payload", dn_payload, 8'h33);
        up_req = '0;
        tick;
        chk("mr_txn2", txn_count, 2);
        // spurious dn_rsp while idle
        dn_rsp = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick;
            chk("sp_up_rsp", up_rsp, 0);
            chk("sp_dn_req", dn_req, 0);
        end
        chk("sp_txn", txn_count, 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
